// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the ALU opcode sweep controller.
package alu_pkg;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned NUM_OPS = 1 << SEL_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/alu_result_buf.sv
// Per-opcode result register file: one write port, one registered read port.
module alu_result_buf
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [SEL_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [SEL_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [NUM_OPS];

   // Read samples the pre-write contents, so a same-cycle write returns the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_OPS); i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
         if (we) begin
            mem[waddr] <= wdata;
         end
      end
   end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Self-test initiator: latches two operands, steps the ALU opcode through every
// value, waits SETTLE cycles per opcode and captures the result into a buffer.
module alu_sweep_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             results_valid,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_s,
   input  logic [WIDTH-1:0] alu_r,
   input  logic [SEL_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned CNT_W       = 4;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_OPS - 1);

   sweep_state_t     state, stateNext;
   logic [SEL_W-1:0] sel, selNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             busyNext, doneNext, validNext;
   logic [WIDTH-1:0] aNext, bNext;
   logic [SEL_W-1:0] sNext;
   logic             bufWe;

   // State and registered ALU drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sel           <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         results_valid <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_s         <= '0;
      end else begin
         state         <= stateNext;
         sel           <= selNext;
         cnt           <= cntNext;
         busy          <= busyNext;
         done          <= doneNext;
         results_valid <= validNext;
         alu_a         <= aNext;
         alu_b         <= bNext;
         alu_s         <= sNext;
      end
   end

   // Next-state and next-output decode; outputs are computed one edge ahead.
   always_comb begin
      stateNext = state;
      selNext   = sel;
      cntNext   = cnt;
      busyNext  = busy;
      doneNext  = 1'b0;
      validNext = results_valid;
      aNext     = alu_a;
      bNext     = alu_b;
      sNext     = alu_s;
      bufWe     = 1'b0;

      unique case (state)
         IDLE: begin
            busyNext = 1'b0;
            sNext    = '0;
            if (start) begin
               stateNext = WAIT;
               aNext     = a_in;
               bNext     = b_in;
               selNext   = '0;
               cntNext   = '0;
               validNext = 1'b0;
               busyNext  = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == SETTLE_LAST) begin
               bufWe   = 1'b1;
               cntNext = '0;
               if (sel == SEL_LAST) begin
                  stateNext = DONE;
                  doneNext  = 1'b1;
                  sNext     = '0;
               end else begin
                  selNext = sel + 1'b1;
                  sNext   = sel + 1'b1;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            validNext = 1'b1;
         end
         default: begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            sNext     = '0;
         end
      endcase
   end

   alu_result_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (bufWe),
      .waddr (sel),
      .wdata (alu_r),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=1 and SETTLE=3) driven by a stub ALU.
module tb_alu_sweep_ctrl;

   localparam int NOPS = 8;
   localparam int S0   = 1;
   localparam int S1   = 3;

   typedef struct {
      logic       busy;
      logic       done;
      logic       rv;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] s;
      bit         chkS;
      logic [7:0] rd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] aIn, bIn;
   logic [2:0] rdAddr = 3'd0;

   logic       busyO [2];
   logic       doneO [2];
   logic       rvO   [2];
   logic [7:0] aluA  [2];
   logic [7:0] aluB  [2];
   logic [2:0] aluS  [2];
   logic [7:0] aluR  [2];
   logic [7:0] rdData[2];

   logic [2:0] hist0 = 3'd0;
   logic [2:0] hist1 = 3'd0;

   int checks = 0;
   int errors = 0;

   exp_t expQ[2][$];

   always #5 clk = ~clk;

   alu_sweep_ctrl #(.SETTLE(S0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .a_in(aIn), .b_in(bIn),
      .busy(busyO[0]), .done(doneO[0]), .results_valid(rvO[0]),
      .alu_a(aluA[0]), .alu_b(aluB[0]), .alu_s(aluS[0]), .alu_r(aluR[0]),
      .rd_addr(rdAddr), .rd_data(rdData[0])
   );

   alu_sweep_ctrl #(.SETTLE(S1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a_in(aIn), .b_in(bIn),
      .busy(busyO[1]), .done(doneO[1]), .results_valid(rvO[1]),
      .alu_a(aluA[1]), .alu_b(aluB[1]), .alu_s(aluS[1]), .alu_r(aluR[1]),
      .rd_addr(rdAddr), .rd_data(rdData[1])
   );

   // Stub ALU: R = A + S. The slow instance returns garbage until S has been stable 3 cycles.
   always @(posedge clk) begin
      hist1 <= hist0;
      hist0 <= aluS[1];
   end

   always_comb begin
      aluR[0] = aluA[0] + 8'(aluS[0]);
      aluR[1] = (aluS[1] == hist0 && aluS[1] == hist1) ? aluA[1] + 8'(aluS[1]) : 8'hEE;
   end

   // Reference model: sweep timeline measured in edges since the accepting edge.
   int         cyc = 0;
   bit         act [2];
   int         e0  [2];
   logic [7:0] mb  [2][NOPS];
   logic       rvM [2];
   logic [7:0] ma  [2];
   logic [7:0] mbB [2];
   int         ms, mt;
   exp_t       me;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ms = (d == 0) ? S0 : S1;
         if (rst) begin
            act[d] = 1'b0;
            rvM[d] = 1'b0;
            ma[d]  = 8'd0;
            mbB[d] = 8'd0;
            for (int k = 0; k < NOPS; k++) mb[d][k] = 8'd0;
            me.rd = 8'd0;
         end else begin
            me.rd = mb[d][rdAddr];
            if (act[d]) begin
               mt = cyc - e0[d];
               if (mt % ms == 0 && mt / ms >= 1 && mt / ms <= NOPS)
                  mb[d][mt / ms - 1] = ma[d] + 8'(mt / ms - 1);
               if (mt == NOPS * ms + 1) begin
                  act[d] = 1'b0;
                  rvM[d] = 1'b1;
               end
            end else if (start) begin
               act[d] = 1'b1;
               e0[d]  = cyc;
               ma[d]  = aIn;
               mbB[d] = bIn;
               rvM[d] = 1'b0;
            end
         end
         mt      = act[d] ? cyc - e0[d] : -1;
         me.busy = act[d] && mt <= NOPS * ms;
         me.done = act[d] && mt == NOPS * ms;
         me.chkS = !act[d] || mt < NOPS * ms;
         me.s    = act[d] ? 3'(mt / ms) : 3'd0;
         me.rv   = rvM[d];
         me.a    = ma[d];
         me.b    = mbB[d];
         expQ[d].push_back(me);
      end
      cyc++;
   end

   task automatic check(input string name, input int d, input logic [7:0] actual, input logic [7:0] want);
      checks++;
      if (actual !== want) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, actual, want);
      end
   endtask

   // Monitor: compares registered outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (expQ[d].size() > 0) begin
            e = expQ[d].pop_front();
            check("busy", d, 8'(busyO[d]), 8'(e.busy));
            check("done", d, 8'(doneO[d]), 8'(e.done));
            check("results_valid", d, 8'(rvO[d]), 8'(e.rv));
            check("alu_a", d, aluA[d], e.a);
            check("alu_b", d, aluB[d], e.b);
            check("rd_data", d, rdData[d], e.rd);
            if (e.chkS) check("alu_s", d, 8'(aluS[d]), 8'(e.s));
         end
      end
   end

   always @(negedge clk) rdAddr = 3'($urandom_range(0, 7));

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] a, input logic [7:0] b);
      aIn = a; bIn = b; start = 1'b1;
      cycles(1);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; aIn = 8'd0; bIn = 8'd0;
      cycles(3);
      rst = 1'b0;
      cycles(2);

      // Single sweep, operands 100/50.
      pulse(8'd100, 8'd50);
      cycles(30);

      // Start while busy must be ignored.
      pulse(8'd100, 8'd50);
      cycles(3);
      pulse(8'd7, 8'd9);
      cycles(30);

      // Reset mid-sweep, then a clean sweep.
      pulse(8'd100, 8'd50);
      cycles(4);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(3);
      pulse(8'd20, 8'd30);
      cycles(30);

      // Level-held start: back-to-back sweeps.
      aIn = 8'd100; bIn = 8'd50; start = 1'b1;
      cycles(20);
      start = 1'b0;
      cycles(30);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         start = ($urandom_range(0, 7) == 0);
         aIn   = 8'($urandom);
         bIn   = 8'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
         cycles(1);
      end
      rst = 1'b0; start = 1'b0;
      cycles(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
